// File: rtl/serial_alu_seq.sv
// serial_alu_seq
//   Bit-serial sequencer wrapped around a single external alu_1bit slice.
//   An accepted start latches op_a, op_b and alu_ctl. The slice is then driven
//   one bit per clock, LSB first, with the carry held in a register between
//   bits. After WIDTH bits the word result and the zero, overflow and carry
//   flags are committed together, and done pulses for one cycle.
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   start              request, sampled only while busy=0
//   op_a, op_b         WIDTH-bit operands, latched on an accepted start
//   alu_ctl            {ainvert, bnegate, sel[1:0]}, latched on an accepted start
//   busy, done         busy while processing a word; done pulses on commit
//   result             last committed result
//   zero               committed result == 0
//   overflow           signed overflow of the add/sub path (0 for logic ops)
//   carry_out          cout of the MSB slice
//   s_a .. s_op        slice-facing drive, combinational from registers
//   s_result, s_cout   slice outputs
module serial_alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             s_a,
    output logic             s_b,
    output logic             s_cin,
    output logic             s_ainvert,
    output logic             s_bnegate,
    output logic             s_less,
    output logic [2:0]       s_op,
    input  logic             s_result,
    input  logic             s_cout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       ctl_reg;
    logic [CNT_W-1:0] idx;
    logic             carry_reg;
    logic [WIDTH-1:0] shift_reg;

    logic [WIDTH-1:0] final_bits;
    logic             arith;
    logic             ovf_next;
    logic [WIDTH-1:0] result_next;

    // Slice drive. SLT sweeps the sum path with b negated; the slice's LESS
    // input is never used, the set bit is rebuilt from the MSB sum at commit.
    assign s_a       = a_reg[idx];
    assign s_b       = b_reg[idx];
    assign s_ainvert = ctl_reg[3];
    assign s_bnegate = ctl_reg[2] | (ctl_reg[1:0] == 2'b11);
    assign s_cin     = (idx == '0) ? s_bnegate : carry_reg;
    assign s_less    = 1'b0;

    always_comb begin
        s_op = 3'b100;
        case (ctl_reg[1:0])
            2'b00:   s_op = 3'b000;
            2'b01:   s_op = 3'b001;
            default: s_op = 3'b100;
        endcase
    end

    // Commit values, meaningful on the final RUN edge. carry_reg still holds
    // the carry into the MSB there, s_cout is the carry out of it.
    assign last_bit    = (idx == LAST);
    assign final_bits  = {s_result, shift_reg[WIDTH-2:0]};
    assign arith       = ctl_reg[1];
    assign ovf_next    = arith & (carry_reg ^ s_cout);
    assign result_next = (ctl_reg[1:0] == 2'b11)
                         ? {{(WIDTH-1){1'b0}}, s_result ^ ovf_next}
                         : final_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            ctl_reg   <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            shift_reg <= '0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            ctl_reg   <= alu_ctl;
            idx       <= '0;
            carry_reg <= 1'b0;
        end else if (state == RUN) begin
            shift_reg[idx] <= s_result;
            carry_reg      <= s_cout;
            if (last_bit) begin
                idx       <= '0;
                result    <= result_next;
                zero      <= (result_next == '0);
                overflow  <= ovf_next;
                carry_out <= s_cout;
            end else begin
                idx <= idx + CNT_W'(1);
            end
        end
    end

endmodule
